// File: rtl/bist_pkg.sv
// Shared BIST definitions: session state encoding and default SISR/LFSR
// constants, so the pattern generator and the signature analyzer agree on widths.
package bist_pkg;

    // Session state of the signature analyzer.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } bist_state_t;

    // Default register width and feedback polynomial (CRC-CCITT taps, Galois form).
    localparam int          BIST_SIG_W = 16;
    localparam logic [15:0] BIST_POLY  = 16'h1021;
    localparam logic [15:0] BIST_SEED  = 16'h0000;

    // Total number of shift bits unloaded in one session.
    function automatic int bist_total_bits(input int chain_len, input int num_patterns);
        return chain_len * num_patterns;
    endfunction

endpackage

// File: rtl/bist_sisr.sv
// Serial-input signature register: pure shift/feedback datapath.
// load has priority over en; with neither asserted the signature holds.
module bist_sisr
    import bist_pkg::*;
#(
    parameter int               SIG_W = BIST_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(BIST_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(BIST_SEED)
) (
    input  logic             CLK,
    input  logic             load,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;
    logic             w_fb;
    logic [SIG_W-1:0] w_next;

    // Galois step: the outgoing MSB mixed with the serial input decides whether the taps fold in.
    assign w_fb   = r_sig[SIG_W-1] ^ din;
    assign w_next = {r_sig[SIG_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);

    // Signature register: reload to seed, compact one bit, or hold.
    always_ff @(posedge CLK) begin
        if (load) begin
            r_sig <= SEED;
        end else if (en) begin
            r_sig <= w_next;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/bist_signature_analyzer.sv
// Response end of the BIST loop: compacts the scan-out stream into a SISR
// while SE=1, counts unloaded bits, then compares against GOLDEN and reports DONE/PASS.
//
// START is a one-cycle request pulse with no ready back-pressure: it is accepted
// only when the FSM is in IDLE or DONE and silently dropped in COMPACT/COMPARE.
// SE/SO_IN form a qualifier/data pair: SO_IN is only meaningful in cycles where
// SE=1 and the FSM is in COMPACT; every such cycle counts exactly one bit.
module bist_signature_analyzer
    import bist_pkg::*;
#(
    parameter int               SIG_W        = BIST_SIG_W,
    parameter logic [SIG_W-1:0] POLY         = SIG_W'(BIST_POLY),
    parameter logic [SIG_W-1:0] SEED         = SIG_W'(BIST_SEED),
    parameter int               CHAIN_LEN    = 8,
    parameter int               NUM_PATTERNS = 32,
    parameter int               SKIP_BITS    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SE,
    input  logic             SO_IN,
    input  logic [SIG_W-1:0] GOLDEN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [SIG_W-1:0] SIG,
    output bist_state_t      DBG_STATE
);

    localparam int             TOTAL    = bist_total_bits(CHAIN_LEN, NUM_PATTERNS);
    localparam int             CNT_W    = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);
    localparam logic [31:0]    SKIP_U   = 32'(SKIP_BITS);

    bist_state_t      r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_start_acc;
    logic             w_shift;
    logic [31:0]      w_cnt_ext;
    logic             w_in_window;
    logic             w_sisr_load;
    logic             w_sisr_en;
    logic [SIG_W-1:0] w_sig;

    // Decode accepted START and the compaction window; the leading SKIP_BITS bits are counted only.
    always_comb begin
        w_start_acc = START && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_shift     = (r_state == ST_COMPACT) && SE;
        w_cnt_ext   = 32'(r_bit_cnt);
        w_in_window = (w_cnt_ext >= SKIP_U);
        w_sisr_load = RST || w_start_acc;
        w_sisr_en   = w_shift && w_in_window;
    end

    bist_sisr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_sisr (
        .CLK  (CLK),
        .load (w_sisr_load),
        .en   (w_sisr_en),
        .din  (SO_IN),
        .sig  (w_sig)
    );

    // Session FSM with bit counter and registered BUSY/DONE/PASS; reset wins over everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        r_state   <= ST_COMPACT;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                    end
                end
                ST_COMPACT: begin
                    // SE=0 is a capture cycle: count and signature both hold.
                    if (SE) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_CNT) begin
                            r_state <= ST_COMPARE;
                        end
                    end
                end
                ST_COMPARE: begin
                    r_pass  <= (w_sig == GOLDEN);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign PASS      = r_pass;
    assign SIG       = w_sig;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Directed bench for bist_signature_analyzer: two instances (no skip, and
// SKIP_BITS=8 over two patterns); sel_b chooses which one the stimulus drives.
module tb_bist_signature_analyzer;
    import bist_pkg::*;

    localparam int          W    = 16;
    localparam logic [15:0] POLY = 16'h1021;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start;
    logic         se;
    logic         so_in;
    logic [W-1:0] golden;
    logic         sel_b;

    logic rst_a, start_a, se_a;
    logic rst_b, start_b, se_b;
    logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [W-1:0] sig_a, sig_b;
    bist_state_t  st_a, st_b;

    // The unselected instance is held in reset.
    assign rst_a   = rst | sel_b;
    assign start_a = start & ~sel_b;
    assign se_a    = se & ~sel_b;
    assign rst_b   = rst | ~sel_b;
    assign start_b = start & sel_b;
    assign se_b    = se & sel_b;

    logic         obs_busy, obs_done, obs_pass;
    logic [W-1:0] obs_sig;
    bist_state_t  obs_st;
    assign obs_busy = sel_b ? busy_b : busy_a;
    assign obs_done = sel_b ? done_b : done_a;
    assign obs_pass = sel_b ? pass_b : pass_a;
    assign obs_sig  = sel_b ? sig_b  : sig_a;
    assign obs_st   = sel_b ? st_b   : st_a;

    bist_signature_analyzer #(
        .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000),
        .CHAIN_LEN(8), .NUM_PATTERNS(1), .SKIP_BITS(0)
    ) dut_a (
        .CLK(clk), .RST(rst_a), .START(start_a), .SE(se_a), .SO_IN(so_in),
        .GOLDEN(golden), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a),
        .SIG(sig_a), .DBG_STATE(st_a)
    );

    bist_signature_analyzer #(
        .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000),
        .CHAIN_LEN(8), .NUM_PATTERNS(2), .SKIP_BITS(8)
    ) dut_b (
        .CLK(clk), .RST(rst_b), .START(start_b), .SE(se_b), .SO_IN(so_in),
        .GOLDEN(golden), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b),
        .SIG(sig_b), .DBG_STATE(st_b)
    );

    // ---------------- scoreboard ----------------
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic         pass_q[$];
    logic [W-1:0] m_sig;
    int           m_cnt;
    int           m_skip;

    function automatic logic [W-1:0] sisr_ref(input logic [W-1:0] s, input logic b);
        logic fb;
        fb = s[W-1] ^ b;
        return {s[W-2:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sig"},   32'(obs_sig), 32'h0);
        check({tag, "_busy"},  32'(obs_busy), 32'h0);
        check({tag, "_done"},  32'(obs_done), 32'h0);
        check({tag, "_pass"},  32'(obs_pass), 32'h0);
        check({tag, "_state"}, 32'(obs_st), 32'(ST_IDLE));
    endtask

    // START with SE=1/SO_IN=1 in the same cycle: those must not be sampled.
    task automatic start_session(input string tag, input logic [W-1:0] gold);
        golden = gold;
        start  = 1'b1;
        se     = 1'b1;
        so_in  = 1'b1;
        step();
        start  = 1'b0;
        se     = 1'b0;
        m_sig  = 16'h0000;
        m_cnt  = 0;
        check({tag, "_start_sig"},   32'(obs_sig), 32'h0);
        check({tag, "_start_busy"},  32'(obs_busy), 32'h1);
        check({tag, "_start_done"},  32'(obs_done), 32'h0);
        check({tag, "_start_pass"},  32'(obs_pass), 32'h0);
        check({tag, "_start_state"}, 32'(obs_st), 32'(ST_COMPACT));
    endtask

    task automatic shift(input logic b);
        se    = 1'b1;
        so_in = b;
        if (m_cnt >= m_skip) m_sig = sisr_ref(m_sig, b);
        m_cnt++;
        step();
    endtask

    task automatic gap(input int n);
        se = 1'b0;
        repeat (n) begin
            so_in = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    task automatic shift_impulse();
        shift(1'b1);
        for (int i = 0; i < 7; i++) shift(1'b0);
    endtask

    // Called right after the last shift edge; SE stays 1 to show later shifts are ignored.
    task automatic finish(input string tag);
        logic [W-1:0] e_sig;
        logic         e_pass;
        se    = 1'b1;
        so_in = 1'b1;
        check({tag, "_cmp_busy"},  32'(obs_busy), 32'h1);
        check({tag, "_cmp_done"},  32'(obs_done), 32'h0);
        check({tag, "_cmp_state"}, 32'(obs_st), 32'(ST_COMPARE));
        step();
        e_sig  = exp_q.pop_front();
        e_pass = pass_q.pop_front();
        check({tag, "_done"},  32'(obs_done), 32'h1);
        check({tag, "_busy"},  32'(obs_busy), 32'h0);
        check({tag, "_sig"},   32'(obs_sig), 32'(e_sig));
        check({tag, "_pass"},  32'(obs_pass), 32'(e_pass));
        repeat (3) step();
        check({tag, "_frozen_sig"},  32'(obs_sig), 32'(e_sig));
        check({tag, "_frozen_pass"}, 32'(obs_pass), 32'(e_pass));
        check({tag, "_frozen_done"}, 32'(obs_done), 32'h1);
        se = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic         rb[8];
        logic [W-1:0] e;

        rst = 1'b1; start = 1'b0; se = 1'b0; so_in = 1'b0;
        golden = '0; sel_b = 1'b0; m_skip = 0; m_sig = '0; m_cnt = 0;

        // 1: reset then idle
        repeat (2) step();
        rst = 1'b0;
        repeat (5) step();
        check_idle("t1");

        // 2: single impulse stream
        start_session("t2", 16'h9188);
        shift_impulse();
        exp_q.push_back(16'h9188); pass_q.push_back(1'b1);
        finish("t2");

        // 3: same stream with capture gaps, then wrong golden
        start_session("t3a", 16'h9188);
        shift(1'b1); shift(1'b0); gap(3);
        shift(1'b0); shift(1'b0); shift(1'b0); gap(3);
        shift(1'b0); shift(1'b0); shift(1'b0);
        exp_q.push_back(16'h9188); pass_q.push_back(1'b1);
        finish("t3a");

        start_session("t3b", 16'h9189);
        shift_impulse();
        exp_q.push_back(16'h9188); pass_q.push_back(1'b0);
        finish("t3b");

        // 4: all-zero stream, then restart from DONE
        start_session("t4a", 16'h0000);
        for (int i = 0; i < 8; i++) shift(1'b0);
        exp_q.push_back(16'h0000); pass_q.push_back(1'b1);
        finish("t4a");

        start_session("t4b", 16'h9188);
        shift_impulse();
        exp_q.push_back(16'h9188); pass_q.push_back(1'b1);
        finish("t4b");

        // 5a: START inside COMPACT is ignored, count continues
        start_session("t5a", 16'h9188);
        shift(1'b1); shift(1'b0); shift(1'b0); shift(1'b0);
        se = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("t5a_mid_state", 32'(obs_st), 32'(ST_COMPACT));
        check("t5a_mid_sig",   32'(obs_sig), 32'h8108);
        for (int i = 0; i < 4; i++) shift(1'b0);
        exp_q.push_back(16'h9188); pass_q.push_back(1'b1);
        finish("t5a");

        // 5b: RST at bit 4 aborts the session
        start_session("t5b", 16'h0000);
        shift(1'b1); shift(1'b0); shift(1'b0);
        rst = 1'b1; se = 1'b1; so_in = 1'b0;
        step();
        rst = 1'b0; se = 1'b0;
        check_idle("t5b_rst");
        for (int i = 0; i < 10; i++) shift(1'b1);
        se = 1'b0;
        check_idle("t5b_after");

        // random streams checked against the reference model
        for (int i = 0; i < 8; i++) rb[i] = 1'($urandom_range(0, 1));
        e = 16'h0000;
        for (int i = 0; i < 8; i++) e = sisr_ref(e, rb[i]);
        start_session("rnd_pass", e);
        for (int i = 0; i < 8; i++) shift(rb[i]);
        exp_q.push_back(m_sig); pass_q.push_back(1'b1);
        finish("rnd_pass");

        start_session("rnd_fail", e ^ 16'h0001);
        for (int i = 0; i < 8; i++) shift(rb[i]);
        exp_q.push_back(m_sig); pass_q.push_back(1'b0);
        finish("rnd_fail");

        // 6: SKIP_BITS=8, two patterns; first pattern is discarded
        sel_b = 1'b1;
        repeat (2) step();
        check_idle("t6_idle");
        m_skip = 8;
        start_session("t6", 16'h9188);
        for (int i = 0; i < 8; i++) shift(1'($urandom_range(0, 1)));
        check("t6_skip_sig", 32'(obs_sig), 32'h0);
        shift_impulse();
        exp_q.push_back(16'h9188); pass_q.push_back(1'b1);
        finish("t6");

        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
